// File: rtl/clock_iface_pkg.sv
// Shared defaults and state type for the clock_iface_reg registered handoff channel.
package clock_iface_pkg;
  localparam int CI_WIDTH_DEF = 8;
  localparam logic [CI_WIDTH_DEF-1:0] CI_RESET_DATA_DEF = 8'h00;

  // Holding state; CI_FULL is exactly the valid output.
  typedef enum logic {CI_IDLE = 1'b0, CI_FULL = 1'b1} ci_state_t;
endpackage

// File: rtl/clock_iface_reg_if.sv
// Producer/consumer bus for clock_iface_reg. CLOCK_IFACE_PARITY_EN adds parity, chk_en, par_err.
interface clock_iface_reg_if
  import clock_iface_pkg::*;
#(
  parameter int WIDTH = CI_WIDTH_DEF
);
  logic             wr_en;
  logic [WIDTH-1:0] wr_data;
  logic             rd_ack;
  logic             clr;
  logic [WIDTH-1:0] data;
  logic             valid;
  logic             overrun;
`ifdef CLOCK_IFACE_PARITY_EN
  logic             parity;
  logic             chk_en;
  logic             par_err;

  modport master (output wr_en, wr_data, rd_ack, clr, chk_en,
                  input  data, valid, overrun, parity, par_err);
  modport slave  (input  wr_en, wr_data, rd_ack, clr, chk_en,
                  output data, valid, overrun, parity, par_err);
`else
  modport master (output wr_en, wr_data, rd_ack, clr,
                  input  data, valid, overrun);
  modport slave  (input  wr_en, wr_data, rd_ack, clr,
                  output data, valid, overrun);
`endif
endinterface

// File: rtl/clock_iface_parity.sv
// XOR-reduce of the incoming write word plus check of the held word against its stored parity.
module clock_iface_parity #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] wr_data,
  input  logic [WIDTH-1:0] data,
  input  logic             parity,
  input  logic             en,
  output logic             gen,
  output logic             err
);
  assign gen = ^wr_data;
  assign err = en & (parity ^ (^data));
endmodule

// File: rtl/clock_iface_reg.sv
// Single-entry registered data/valid handoff with sticky overrun and synchronous clear.
// Optional CLOCK_IFACE_PARITY_EN stores write parity and flags mismatches on the held word.
module clock_iface_reg
  import clock_iface_pkg::*;
#(
  parameter int               WIDTH      = CI_WIDTH_DEF,
  parameter logic [WIDTH-1:0] RESET_DATA = WIDTH'(CI_RESET_DATA_DEF)
) (
  input logic             clk,
  input logic             rst_n,
  clock_iface_reg_if.slave bus
);
  ci_state_t        state;
  logic [WIDTH-1:0] data_q;
  logic             ovr_q;

  // clr wins over write/ack; a write on a full entry only overruns if the old word wasn't acked.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= CI_IDLE;
      data_q <= RESET_DATA;
      ovr_q  <= 1'b0;
    end else if (bus.clr) begin
      state <= CI_IDLE;
      ovr_q <= 1'b0;
    end else if (bus.wr_en) begin
      data_q <= bus.wr_data;
      state  <= CI_FULL;
      if (state == CI_FULL && !bus.rd_ack) ovr_q <= 1'b1;
    end else if (bus.rd_ack) begin
      state <= CI_IDLE;
    end
  end

  assign bus.data    = data_q;
  assign bus.valid   = (state == CI_FULL);
  assign bus.overrun = ovr_q;

`ifdef CLOCK_IFACE_PARITY_EN
  logic par_q;
  logic par_gen;

  clock_iface_parity #(.WIDTH(WIDTH)) u_par (
    .wr_data (bus.wr_data),
    .data    (data_q),
    .parity  (par_q),
    .en      (bus.chk_en & bus.valid),
    .gen     (par_gen),
    .err     (bus.par_err)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                      par_q <= ^RESET_DATA;
    else if (!bus.clr && bus.wr_en)  par_q <= par_gen;
  end

  assign bus.parity = par_q;
`endif
endmodule

// File: tb/tb_clock_iface_reg.sv
// Self-checking bench for clock_iface_reg: directed scenarios then randomized traffic vs a reference model.
module tb_clock_iface_reg;
  logic clk = 1'b0;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;

  // reference model of the handoff register
  logic [7:0] m_data;
  logic       m_valid;
  logic       m_ovr;

  clock_iface_reg_if #(.WIDTH(8)) bus ();

  clock_iface_reg #(.WIDTH(8), .RESET_DATA(8'h00)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic chk_all(input string tag);
    chk({tag, ".data"},    32'(bus.data),    32'(m_data));
    chk({tag, ".valid"},   32'(bus.valid),   32'(m_valid));
    chk({tag, ".overrun"}, 32'(bus.overrun), 32'(m_ovr));
`ifdef CLOCK_IFACE_PARITY_EN
    chk({tag, ".parity"},  32'(bus.parity),  32'(^m_data));
    chk({tag, ".par_err"}, 32'(bus.par_err), 32'd0);
`endif
  endtask

  task automatic model_reset();
    m_data  = 8'h00;
    m_valid = 1'b0;
    m_ovr   = 1'b0;
  endtask

  // Drive one cycle of inputs, take the edge, advance the model, check just after the edge.
  task automatic step(input string tag, input logic we, input logic [7:0] wd,
                      input logic ack, input logic c);
    bus.wr_en   = we;
    bus.wr_data = wd;
    bus.rd_ack  = ack;
    bus.clr     = c;
    @(posedge clk);
    if (c) begin
      m_valid = 1'b0;
      m_ovr   = 1'b0;
    end else if (we) begin
      if (m_valid && !ack) m_ovr = 1'b1;
      m_data  = wd;
      m_valid = 1'b1;
    end else if (ack) begin
      m_valid = 1'b0;
    end
    #1;
    bus.wr_en  = 1'b0;
    bus.rd_ack = 1'b0;
    bus.clr    = 1'b0;
    chk_all(tag);
  endtask

  // Asynchronous reset pulse landing between clock edges.
  task automatic mid_reset(input string tag);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    chk_all(tag);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n       = 1'b0;
    bus.wr_en   = 1'b0;
    bus.wr_data = 8'h00;
    bus.rd_ack  = 1'b0;
    bus.clr     = 1'b0;
`ifdef CLOCK_IFACE_PARITY_EN
    bus.chk_en  = 1'b1;
`endif
    model_reset();
    #1;
    chk_all("reset_t0");
    repeat (2) @(posedge clk);
    #1;
    chk_all("reset_hold");
    @(negedge clk);
    rst_n = 1'b1;

    step("wr_aa",      1'b1, 8'hAA, 1'b0, 1'b0);
    step("ack_aa",     1'b0, 8'h00, 1'b1, 1'b0);
    step("ack_empty",  1'b0, 8'h00, 1'b1, 1'b0);
    step("wr_11",      1'b1, 8'h11, 1'b0, 1'b0);
    step("wr_22_ovr",  1'b1, 8'h22, 1'b0, 1'b0);
    step("idle_sticky",1'b0, 8'h00, 1'b0, 1'b0);
    step("clr",        1'b0, 8'h00, 1'b0, 1'b1);
    step("wr_33",      1'b1, 8'h33, 1'b0, 1'b0);
    step("wr_44_ack",  1'b1, 8'h44, 1'b1, 1'b0);
    step("clr_vs_wr",  1'b1, 8'h55, 1'b1, 1'b1);
    step("wr_07",      1'b1, 8'h07, 1'b0, 1'b0);
    step("wr_5c",      1'b1, 8'h5C, 1'b1, 1'b0);
    mid_reset("async_rst");
    step("post_rst_wr",1'b1, 8'hC3, 1'b0, 1'b0);

    for (int i = 0; i < 400; i++) begin
      logic we, ack, c;
      logic [7:0] wd;
      we  = 1'($urandom_range(0, 1));
      ack = 1'($urandom_range(0, 1));
      c   = ($urandom_range(0, 9) == 0);
      wd  = 8'($urandom);
`ifdef CLOCK_IFACE_PARITY_EN
      bus.chk_en = 1'($urandom_range(0, 1));
`endif
      step("rand", we, wd, ack, c);
      if ($urandom_range(0, 49) == 0) mid_reset("rand_rst");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
